// File: rtl/data_fifo.sv
// data_fifo: single-clock word buffer between the DMA/register side and the SD data path.
// Latency: a pop is answered with a registered word one cycle later. There is no fall-through.
// Backpressure: a push is dropped when full unless a pop is accepted in the same cycle. A pop is dropped when empty.
//
// Ports:
//   iClock, iReset      clock and asynchronous active-high reset
//   iWriteRead          1 = host->card, 0 = card->host; selects the oFIFO_ok rule
//   iFlush              synchronous clear of contents, read word and error flags
//   iPush, iPush_data   write request and word
//   iPop, oPop_data     read request and registered read word
//   oFull, oEmpty       count == DEPTH, count == 0
//   oCount              stored words, 0..DEPTH
//   oFIFO_ok            a full block can be serviced in the current direction
//   oOverflow           sticky error flag, present only with DATA_FIFO_ERR_EN
//   oUnderflow          sticky error flag, present only with DATA_FIFO_ERR_EN
// Optional feature: define DATA_FIFO_ERR_EN to build the sticky error flags.
// Without it, both flags are tied to 0.
module data_fifo #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 4,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  iWriteRead,
  input  logic                  iFlush,
  input  logic                  iPush,
  input  logic [DATA_WIDTH-1:0] iPush_data,
  input  logic                  iPop,
  output logic [DATA_WIDTH-1:0] oPop_data,
  output logic                  oFull,
  output logic                  oEmpty,
  output logic [ADDR_WIDTH:0]   oCount,
  output logic                  oFIFO_ok,
  output logic                  oOverflow,
  output logic                  oUnderflow
);

  localparam int                DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] BLOCK_C = (ADDR_WIDTH+1)'(BLOCK_WORDS);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;
  logic [ADDR_WIDTH:0]   space;
  logic                  full, empty, push_acc, pop_acc;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // Push and pop together while full is a pass-through that keeps count at DEPTH.
  // The read takes the old mem[rptr] even though wptr == rptr.
  assign push_acc = iPush & (~full | iPop);
  assign pop_acc  = iPop & ~empty;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    pop_data_d = pop_data_q;
    if (iFlush) begin
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      pop_data_d = '0;
    end else begin
      if (push_acc) wptr_d = wptr_q + 1'b1;
      if (pop_acc) begin
        rptr_d     = rptr_q + 1'b1;
        pop_data_d = mem_q[rptr_q];
      end
      count_d = count_q + {{ADDR_WIDTH{1'b0}}, push_acc} - {{ADDR_WIDTH{1'b0}}, pop_acc};
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      pop_data_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      pop_data_q <= pop_data_d;
    end
  end

  // The storage array is not reset. Its words become unreachable once the pointers and count clear.
  always_ff @(posedge iClock) begin
    if (push_acc && !iFlush) mem_q[wptr_q] <= iPush_data;
  end

  assign oPop_data = pop_data_q;
  assign oFull     = full;
  assign oEmpty    = empty;
  assign oCount    = count_q;

  // count never exceeds DEPTH, so this subtraction cannot wrap.
  assign space    = DEPTH_C - count_q;
  assign oFIFO_ok = iWriteRead ? (count_q >= BLOCK_C) : (space >= BLOCK_C);

`ifdef DATA_FIFO_ERR_EN
  logic ovf_q, ovf_d, unf_q, unf_d;

  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (iFlush) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      if (iPush && full && !iPop) ovf_d = 1'b1;
      if (iPop && empty)          unf_d = 1'b1;
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign oOverflow  = ovf_q;
  assign oUnderflow = unf_q;
`else
  assign oOverflow  = 1'b0;
  assign oUnderflow = 1'b0;
`endif

endmodule

// File: tb/tb_data_fifo.sv
// tb_data_fifo: directed stimulus for data_fifo with a queue-based reference model.
// One process compares the DUT against the model on every falling edge.
// Literal expectations at key points pin the model to hand-computed values.
module tb_data_fifo;

`ifdef DATA_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        iClock = 1'b0;
  logic        iReset = 1'b1;
  logic        iWriteRead = 1'b1;
  logic        iFlush = 1'b0;
  logic        iPush = 1'b0;
  logic [31:0] iPush_data = '0;
  logic        iPop = 1'b0;
  logic [31:0] oPop_data;
  logic        oFull, oEmpty, oFIFO_ok, oOverflow, oUnderflow;
  logic [4:0]  oCount;

  int errors = 0;
  int checks = 0;
  bit run_cmp = 1'b0;

  data_fifo dut (
    .iClock(iClock), .iReset(iReset), .iWriteRead(iWriteRead), .iFlush(iFlush),
    .iPush(iPush), .iPush_data(iPush_data), .iPop(iPop), .oPop_data(oPop_data),
    .oFull(oFull), .oEmpty(oEmpty), .oCount(oCount), .oFIFO_ok(oFIFO_ok),
    .oOverflow(oOverflow), .oUnderflow(oUnderflow)
  );

  always #5 iClock = ~iClock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words plus the last popped word.
  logic [31:0] mq[$];
  logic [31:0] m_pd = '0;
  bit          m_ovf = 1'b0, m_unf = 1'b0;
  int          m_n;

  always @(posedge iClock or posedge iReset) begin
    if (iReset || iFlush) begin
      mq.delete();
      m_pd  = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_n = mq.size();
      if (ERR_EN && iPush && m_n == 16 && !iPop) m_ovf = 1'b1;
      if (ERR_EN && iPop && m_n == 0) m_unf = 1'b1;
      if (iPop && m_n > 0) m_pd = mq.pop_front();
      if (iPush && (m_n < 16 || iPop)) mq.push_back(iPush_data);
    end
  end

  always @(negedge iClock) begin
    if (run_cmp) begin
      chk("cmp_count", 32'(oCount), mq.size());
      chk("cmp_empty", 32'(oEmpty), 32'(mq.size() == 0));
      chk("cmp_full", 32'(oFull), 32'(mq.size() == 16));
      chk("cmp_ok", 32'(oFIFO_ok),
          32'(iWriteRead ? (mq.size() >= 4) : (16 - mq.size() >= 4)));
      chk("cmp_pop_data", oPop_data, m_pd);
      chk("cmp_ovf", 32'(oOverflow), 32'(m_ovf));
      chk("cmp_unf", 32'(oUnderflow), 32'(m_unf));
    end
  end

  // Inputs change 2 time units after a rising edge and are held over the next edge.
  task automatic step(input logic push, input logic [31:0] d, input logic pop, input logic flush);
    iPush = push; iPush_data = d; iPop = pop; iFlush = flush;
    @(posedge iClock); #2;
    iPush = 1'b0; iPop = 1'b0; iFlush = 1'b0;
  endtask

  int   pushed, popped, outst;
  logic pu, po;

  initial begin
    @(posedge iClock); #2;
    run_cmp = 1'b1;
    chk("reset_empty", 32'(oEmpty), 1);
    chk("reset_count", 32'(oCount), 0);
    chk("reset_pop_data", oPop_data, 0);
    @(posedge iClock); #2;
    iReset = 1'b0;

    // Advance both pointers to 12 so the ordering run wraps twice.
    for (int k = 0; k < 12; k++) step(1'b1, 32'hA000 + k, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      chk("pre_pop", oPop_data, 32'hA000 + k);
    end

    // T2: interleaved pushes and pops of 0x0..0x13.
    pushed = 0; popped = 0; outst = 0;
    for (int i = 0; i < 40; i++) begin
      pu = (i % 3 != 2) && (pushed < 20);
      po = (i % 3 != 0) && (outst > 0);
      step(pu, 32'(pushed), po, 1'b0);
      if (pu) begin pushed++; outst++; end
      if (po) begin
        chk("t2_order", oPop_data, 32'(popped));
        popped++; outst--;
      end
    end
    chk("t2_all_popped", 32'(popped), 20);

    // T3: fill, overflow, then a simultaneous push and pop while full.
    for (int k = 0; k < 16; k++) step(1'b1, 32'h100 + k, 1'b0, 1'b0);
    chk("t3_full", 32'(oFull), 1);
    chk("t3_count16", 32'(oCount), 16);
    step(1'b1, 32'hDEAD, 1'b0, 1'b0);
    chk("t3_count_after_17th", 32'(oCount), 16);
    chk("t3_ovf", 32'(oOverflow), 32'(ERR_EN));
    step(1'b1, 32'hBEEF, 1'b1, 1'b0);
    chk("t3_pp_count", 32'(oCount), 16);
    chk("t3_pp_oldest", oPop_data, 32'h100);
    for (int k = 1; k < 16; k++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      chk("t3_drain", oPop_data, 32'h100 + k);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    chk("t3_last_beef", oPop_data, 32'hBEEF);
    chk("t3_empty", 32'(oEmpty), 1);

    // T4: pop on empty, then push and pop on empty.
    step(1'b0, '0, 1'b1, 1'b0);
    chk("t4_hold", oPop_data, 32'hBEEF);
    chk("t4_unf", 32'(oUnderflow), 32'(ERR_EN));
    step(1'b1, 32'h55, 1'b1, 1'b0);
    chk("t4_pp_count", 32'(oCount), 1);
    chk("t4_pp_hold", oPop_data, 32'hBEEF);

    // T5: block threshold in both directions.
    step(1'b1, 32'h60, 1'b0, 1'b0);
    step(1'b1, 32'h61, 1'b0, 1'b0);
    chk("t5_wr1_c3", 32'(oFIFO_ok), 0);
    step(1'b1, 32'h62, 1'b0, 1'b0);
    chk("t5_wr1_c4", 32'(oFIFO_ok), 1);
    for (int k = 0; k < 8; k++) step(1'b1, 32'h70 + k, 1'b0, 1'b0);
    iWriteRead = 1'b0; #1;
    chk("t5_wr0_c12", 32'(oFIFO_ok), 1);
    step(1'b1, 32'h80, 1'b0, 1'b0);
    chk("t5_wr0_c13", 32'(oFIFO_ok), 0);
    iWriteRead = 1'b1; #1;
    chk("t5_toggle_c13", 32'(oFIFO_ok), 1);
    chk("t5_toggle_count", 32'(oCount), 13);

    // T6: flush with a concurrent push.
    for (int k = 0; k < 6; k++) step(1'b0, '0, 1'b1, 1'b0);
    chk("t6_count7", 32'(oCount), 7);
    step(1'b1, 32'hF1F1, 1'b0, 1'b1);
    chk("t6_count0", 32'(oCount), 0);
    chk("t6_empty", 32'(oEmpty), 1);
    chk("t6_ovf", 32'(oOverflow), 0);
    chk("t6_unf", 32'(oUnderflow), 0);
    chk("t6_pop_data", oPop_data, 0);
    step(1'b1, 32'h77, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("t6_discarded", oPop_data, 32'h77);

    // T1: asynchronous reset with 5 words stored.
    for (int k = 0; k < 5; k++) step(1'b1, 32'h90 + k, 1'b0, 1'b0);
    chk("t1_count5", 32'(oCount), 5);
    iReset = 1'b1; #1;
    chk("t1_count0", 32'(oCount), 0);
    chk("t1_empty", 32'(oEmpty), 1);
    chk("t1_pop_data", oPop_data, 0);
    chk("t1_ok", 32'(oFIFO_ok), 0);
    @(posedge iClock); #2;
    iReset = 1'b0;
    step(1'b0, '0, 1'b1, 1'b0);
    chk("t1_after_pop_empty", oPop_data, 0);
    step(1'b0, '0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
